// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, configuration codes and helpers for the UART receiver
package uart_pkg;
    localparam int MIN_DIV = 4;
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_START      = 3'd1;
    localparam logic [2:0] ST_DATA       = 3'd2;
    localparam logic [2:0] ST_PARITY     = 3'd3;
    localparam logic [2:0] ST_STOP       = 3'd4;
    localparam logic [2:0] ST_BREAK_WAIT = 3'd5;
    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_EVEN = 2'd1;
    localparam logic [1:0] PARITY_ODD  = 2'd2;
    localparam logic [1:0] PARITY_MARK = 2'd3;
    localparam logic [1:0] DATA_BITS_5 = 2'd0;
    localparam logic [1:0] DATA_BITS_6 = 2'd1;
    localparam logic [1:0] DATA_BITS_7 = 2'd2;
    localparam logic [1:0] DATA_BITS_8 = 2'd3;
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: configuration, serial input and received-character status of the receiver
interface uart_rx_cfg_if #(
    parameter int DIV_W = 16
);
    logic             i_Enable;
    logic [DIV_W-1:0] i_Clks_Per_Bit;
    logic [1:0]       i_Data_Bits;
    logic [1:0]       i_Parity_Mode;
    logic             i_RX_Serial;
    logic             o_RX_DV;
    logic [7:0]       o_RX_Byte;
    logic             o_Parity_Err;
    logic             o_Framing_Err;
    logic             o_Break;
    logic             o_Busy;
    modport slave (
        input  i_Enable, i_Clks_Per_Bit, i_Data_Bits, i_Parity_Mode, i_RX_Serial,
        output o_RX_DV, o_RX_Byte, o_Parity_Err, o_Framing_Err, o_Break, o_Busy
    );
    modport master (
        output i_Enable, i_Clks_Per_Bit, i_Data_Bits, i_Parity_Mode, i_RX_Serial,
        input  o_RX_DV, o_RX_Byte, o_Parity_Err, o_Framing_Err, o_Break, o_Busy
    );
endinterface

// File: rtl/uart_rx_line_filter.sv
// uart_rx_line_filter: 2-FF synchroniser plus registered 3-tap majority filter, idles high
module uart_rx_line_filter (
    input  logic i_Clock,
    input  logic i_Rst,
    input  logic i_Serial,
    output logic o_Filtered
);
    import uart_pkg::*;
    logic [1:0] sync_q;
    logic [1:0] tap_q;
    logic       filt_q;
    // taps are the synchroniser output plus two delayed copies, so one-clock glitches lose the vote
    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            sync_q <= '1;
            tap_q  <= '1;
            filt_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], i_Serial};
            tap_q  <= {tap_q[0], sync_q[1]};
            filt_q <= maj3(sync_q[1], tap_q[0], tap_q[1]);
        end
    end
    assign o_Filtered = filt_q;
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver with parity, framing and break status
module uart_rx_cfg #(
    parameter int DIV_W   = 16,
    parameter int MIN_DIV = 4
) (
    input logic          i_Clock,
    input logic          i_Rst,
    uart_rx_cfg_if.slave rx
);
    import uart_pkg::*;
    logic             filt;
    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, div_in;
    logic [1:0]       nb_q, nb_d, pm_q, pm_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       sh_q, sh_d, byte_q, byte_d;
    logic             par_q, par_d, pbit_q, pbit_d, pe_q, pe_d;
    logic             dv_q, dv_d, perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
    logic             bit_end, half, last_bit, brk;
    uart_rx_line_filter u_filt (
        .i_Clock    (i_Clock),
        .i_Rst      (i_Rst),
        .i_Serial   (rx.i_RX_Serial),
        .o_Filtered (filt)
    );
    assign div_in   = (rx.i_Clks_Per_Bit < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : rx.i_Clks_Per_Bit;
    assign bit_end  = cnt_q == div_q - DIV_W'(1);
    assign half     = cnt_q == ((div_q - DIV_W'(1)) >> 1);
    assign last_bit = idx_q == {1'b1, nb_q};
    // break: every bit of the frame, including any parity bit, read as 0
    assign brk      = (sh_q == '0) && !(pm_q != PARITY_NONE && pbit_q) && !filt;
    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) state_q <= ST_IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        if (!rx.i_Enable) state_d = ST_IDLE;
        else begin
            case (state_q)
                ST_IDLE:       state_d = filt ? ST_IDLE : ST_START;
                ST_START:      state_d = !half ? ST_START : (filt ? ST_IDLE : ST_DATA);
                ST_DATA:       state_d = !(bit_end && last_bit) ? ST_DATA : (pm_q == PARITY_NONE ? ST_STOP : ST_PARITY);
                ST_PARITY:     state_d = bit_end ? ST_STOP : ST_PARITY;
                ST_STOP:       state_d = !bit_end ? ST_STOP : (brk ? ST_BREAK_WAIT : ST_IDLE);
                ST_BREAK_WAIT: state_d = filt ? ST_IDLE : ST_BREAK_WAIT;
                default:       state_d = ST_IDLE;
            endcase
        end
    end
    always_comb begin
        cnt_d  = cnt_q + DIV_W'(1);
        div_d  = div_q;
        nb_d   = nb_q;
        pm_d   = pm_q;
        idx_d  = idx_q;
        sh_d   = sh_q;
        par_d  = par_q;
        pbit_d = pbit_q;
        pe_d   = pe_q;
        dv_d   = 1'b0;
        byte_d = byte_q;
        perr_d = perr_q;
        ferr_d = ferr_q;
        brk_d  = brk_q;
        if (rx.i_Enable) begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (!filt) begin
                        div_d  = div_in;
                        nb_d   = rx.i_Data_Bits;
                        pm_d   = rx.i_Parity_Mode;
                        idx_d  = '0;
                        sh_d   = '0;
                        par_d  = 1'b0;
                        pbit_d = 1'b0;
                        pe_d   = 1'b0;
                    end
                end
                ST_START: if (half) cnt_d = '0;
                ST_DATA: if (bit_end) begin
                    cnt_d       = '0;
                    sh_d[idx_q] = filt;
                    par_d       = par_q ^ filt;
                    idx_d       = idx_q + 3'd1;
                end
                ST_PARITY: if (bit_end) begin
                    cnt_d  = '0;
                    pbit_d = filt;
                    pe_d   = pm_q == PARITY_MARK ? !filt : ((par_q ^ filt) != (pm_q == PARITY_ODD));
                end
                ST_STOP: if (bit_end) begin
                    dv_d   = 1'b1;
                    byte_d = sh_q;
                    perr_d = pe_q;
                    ferr_d = !filt;
                    brk_d  = brk;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            cnt_q  <= '0;
            div_q  <= DIV_W'(MIN_DIV);
            nb_q   <= DATA_BITS_8;
            pm_q   <= PARITY_NONE;
            idx_q  <= '0;
            sh_q   <= '0;
            par_q  <= 1'b0;
            pbit_q <= 1'b0;
            pe_q   <= 1'b0;
            dv_q   <= 1'b0;
            byte_q <= '0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            brk_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            nb_q   <= nb_d;
            pm_q   <= pm_d;
            idx_q  <= idx_d;
            sh_q   <= sh_d;
            par_q  <= par_d;
            pbit_q <= pbit_d;
            pe_q   <= pe_d;
            dv_q   <= dv_d;
            byte_q <= byte_d;
            perr_q <= perr_d;
            ferr_q <= ferr_d;
            brk_q  <= brk_d;
        end
    end
    assign rx.o_RX_DV       = dv_q;
    assign rx.o_RX_Byte     = byte_q;
    assign rx.o_Parity_Err  = perr_q;
    assign rx.o_Framing_Err = ferr_q;
    assign rx.o_Break       = brk_q;
    assign rx.o_Busy        = state_q != ST_IDLE;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed self-checking bench for the configurable UART receiver
module tb_uart_rx_cfg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int D = 16;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int dv_cnt = 0;
    int dv_cyc = 0;
    int dbl = 0;
    int t_start = 0;
    logic dv_prev = 1'b0;
    logic [7:0] last_b = 8'h00;
    logic [7:0] prev_b = 8'h00;

    uart_rx_cfg_if #(.DIV_W(16)) bus ();
    uart_rx_cfg #(.DIV_W(16), .MIN_DIV(4)) dut (.i_Clock(clk), .i_Rst(rst), .rx(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.o_RX_DV) begin
            dv_cnt++;
            dv_cyc = cyc;
            prev_b = last_b;
            last_b = bus.o_RX_Byte;
            if (dv_prev) dbl++;
        end
        dv_prev = bus.o_RX_DV;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit g);
        bus.i_RX_Serial = b;
        if (g) begin
            idle(D / 2);
            bus.i_RX_Serial = ~b;
            idle(1);
            bus.i_RX_Serial = b;
            idle(D / 2 - 1);
        end else idle(D);
    endtask

    task automatic send_frame(input logic [7:0] data, input int nb, input logic has_p,
                              input logic p, input logic stop, input int gl);
        bus.i_RX_Serial = 1'b0;
        t_start = cyc;
        idle(D);
        for (int i = 0; i < nb; i++) send_bit(data[i], i == gl);
        if (has_p) send_bit(p, 1'b0);
        send_bit(stop, 1'b0);
        bus.i_RX_Serial = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(3);
        n_cmp++; if (bus.o_RX_Byte !== 8'h00) begin n_bad++; $display("FAIL reset_byte: got %h want 00", bus.o_RX_Byte); end
        n_cmp++; if ({bus.o_RX_DV, bus.o_Parity_Err, bus.o_Framing_Err, bus.o_Break, bus.o_Busy} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 00000",
                {bus.o_RX_DV, bus.o_Parity_Err, bus.o_Framing_Err, bus.o_Break, bus.o_Busy}); end
        rst = 1'b0;
        idle(8);
        n_cmp++; if (bus.o_Busy !== 1'b0 || dv_cnt !== 0) begin n_bad++; $display("FAIL reset_idle: busy %b dv %0d want 0 0", bus.o_Busy, dv_cnt); end
    endtask

    task automatic test_8n1;
        int base = dv_cnt;
        int lat;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1);
        idle(4);
        lat = dv_cyc - t_start - 1;
        n_cmp++; if (dv_cnt - base !== 1) begin n_bad++; $display("FAIL 8n1_count: got %0d DV want 1", dv_cnt - base); end
        n_cmp++; if (last_b !== 8'hA5) begin n_bad++; $display("FAIL 8n1_byte: got %h want a5", last_b); end
        n_cmp++; if ({bus.o_Parity_Err, bus.o_Framing_Err, bus.o_Break} !== 3'b000) begin
            n_bad++; $display("FAIL 8n1_flags: got %b want 000", {bus.o_Parity_Err, bus.o_Framing_Err, bus.o_Break}); end
        n_cmp++; if (lat < 3 + 8 + 9 * 16 || lat > 3 + 8 + 9 * 16 + 2) begin
            n_bad++; $display("FAIL 8n1_latency: got %0d clocks want 155..157", lat); end
    endtask

    task automatic test_parity;
        bus.i_Data_Bits = 2'd2;
        bus.i_Parity_Mode = 2'd1;
        send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, -1);
        idle(4);
        n_cmp++; if (last_b !== 8'h35 || bus.o_Parity_Err !== 1'b0) begin
            n_bad++; $display("FAIL 7e1_good: got byte %h perr %b want 35 0", last_b, bus.o_Parity_Err); end
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, -1);
        idle(4);
        n_cmp++; if (last_b !== 8'h35 || bus.o_Parity_Err !== 1'b1) begin
            n_bad++; $display("FAIL 7e1_bad: got byte %h perr %b want 35 1", last_b, bus.o_Parity_Err); end
        bus.i_Data_Bits = 2'd3;
        bus.i_Parity_Mode = 2'd0;
        idle(D);
    endtask

    task automatic test_framing;
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, -1);
        idle(4);
        n_cmp++; if (last_b !== 8'h81 || bus.o_Framing_Err !== 1'b1 || bus.o_Break !== 1'b0) begin
            n_bad++; $display("FAIL framing_err: got byte %h ferr %b brk %b want 81 1 0", last_b, bus.o_Framing_Err, bus.o_Break); end
        idle(D);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, -1);
        idle(4);
        n_cmp++; if (last_b !== 8'h3C || {bus.o_Parity_Err, bus.o_Framing_Err, bus.o_Break} !== 3'b000) begin
            n_bad++; $display("FAIL framing_recover: got byte %h flags %b want 3c 000", last_b,
                {bus.o_Parity_Err, bus.o_Framing_Err, bus.o_Break}); end
    endtask

    task automatic test_break;
        int base = dv_cnt;
        bus.i_RX_Serial = 1'b0;
        idle(12 * D);
        n_cmp++; if (dv_cnt - base !== 1) begin n_bad++; $display("FAIL break_count: got %0d DV want 1", dv_cnt - base); end
        n_cmp++; if (last_b !== 8'h00 || bus.o_Break !== 1'b1 || bus.o_Framing_Err !== 1'b1) begin
            n_bad++; $display("FAIL break_flags: got byte %h brk %b ferr %b want 00 1 1", last_b, bus.o_Break, bus.o_Framing_Err); end
        n_cmp++; if (bus.o_Busy !== 1'b1) begin n_bad++; $display("FAIL break_wait: got busy %b want 1", bus.o_Busy); end
        bus.i_RX_Serial = 1'b1;
        idle(8);
        n_cmp++; if (bus.o_Busy !== 1'b0 || dv_cnt - base !== 1) begin
            n_bad++; $display("FAIL break_release: got busy %b dv %0d want 0 1", bus.o_Busy, dv_cnt - base); end
        idle(D);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, -1);
        idle(4);
        n_cmp++; if (last_b !== 8'h5A || {bus.o_Parity_Err, bus.o_Framing_Err, bus.o_Break} !== 3'b000) begin
            n_bad++; $display("FAIL break_next: got byte %h flags %b want 5a 000", last_b,
                {bus.o_Parity_Err, bus.o_Framing_Err, bus.o_Break}); end
    endtask

    task automatic test_glitch;
        int base = dv_cnt;
        bus.i_RX_Serial = 1'b0; idle(1); bus.i_RX_Serial = 1'b1; idle(3 * D);
        n_cmp++; if (bus.o_Busy !== 1'b0) begin n_bad++; $display("FAIL glitch_1clk: got busy %b want 0", bus.o_Busy); end
        bus.i_RX_Serial = 1'b0; idle(2); bus.i_RX_Serial = 1'b1; idle(2 * D);
        bus.i_RX_Serial = 1'b0; idle(D / 4); bus.i_RX_Serial = 1'b1; idle(2 * D);
        n_cmp++; if (bus.o_Busy !== 1'b0 || dv_cnt - base !== 0) begin
            n_bad++; $display("FAIL glitch_false_start: got busy %b dv %0d want 0 0", bus.o_Busy, dv_cnt - base); end
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 2);
        idle(4);
        n_cmp++; if (last_b !== 8'hC3 || dv_cnt - base !== 1) begin
            n_bad++; $display("FAIL glitch_mid_bit: got byte %h dv %0d want c3 1", last_b, dv_cnt - base); end
    endtask

    task automatic test_back_to_back;
        int base = dv_cnt;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, -1);
        idle(4);
        n_cmp++; if (dv_cnt - base !== 2 || prev_b !== 8'h11 || last_b !== 8'h22) begin
            n_bad++; $display("FAIL b2b_bytes: got dv %0d bytes %h %h want 2 11 22", dv_cnt - base, prev_b, last_b); end
        n_cmp++; if (dbl !== 0) begin n_bad++; $display("FAIL b2b_dv_pulse: got %0d consecutive DV want 0", dbl); end
    endtask

    task automatic test_enable;
        int base = dv_cnt;
        bus.i_RX_Serial = 1'b0;
        idle(D);
        send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        bus.i_Enable = 1'b0;
        bus.i_RX_Serial = 1'b1;
        idle(2);
        n_cmp++; if (bus.o_Busy !== 1'b0) begin n_bad++; $display("FAIL enable_abort: got busy %b want 0", bus.o_Busy); end
        idle(10 * D);
        bus.i_Enable = 1'b1;
        idle(D);
        n_cmp++; if (dv_cnt - base !== 0 || bus.o_RX_Byte !== 8'h22) begin
            n_bad++; $display("FAIL enable_hold: got dv %0d byte %h want 0 22", dv_cnt - base, bus.o_RX_Byte); end
    endtask

    task automatic test_rst_abort;
        int base = dv_cnt;
        bus.i_RX_Serial = 1'b0;
        idle(D);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        bus.i_RX_Serial = 1'b0;
        idle(D / 2);
        rst = 1'b1;
        bus.i_RX_Serial = 1'b1;
        idle(2);
        n_cmp++; if ({bus.o_RX_Byte, bus.o_RX_DV, bus.o_Parity_Err, bus.o_Framing_Err, bus.o_Break, bus.o_Busy} !== 13'h0) begin
            n_bad++; $display("FAIL rst_abort_outputs: got byte %h flags %b want 00 00000", bus.o_RX_Byte,
                {bus.o_RX_DV, bus.o_Parity_Err, bus.o_Framing_Err, bus.o_Break, bus.o_Busy}); end
        rst = 1'b0;
        idle(12 * D);
        n_cmp++; if (dv_cnt - base !== 0 || bus.o_Busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_abort_no_dv: got dv %0d busy %b want 0 0", dv_cnt - base, bus.o_Busy); end
    endtask

    task automatic test_5o1;
        bus.i_Data_Bits = 2'd0;
        bus.i_Parity_Mode = 2'd2;
        send_frame(8'h15, 5, 1'b1, 1'b0, 1'b1, -1);
        idle(4);
        n_cmp++; if (last_b !== 8'h15 || {bus.o_Parity_Err, bus.o_Framing_Err, bus.o_Break} !== 3'b000) begin
            n_bad++; $display("FAIL 5o1_good: got byte %h flags %b want 15 000", last_b,
                {bus.o_Parity_Err, bus.o_Framing_Err, bus.o_Break}); end
        send_frame(8'h15, 5, 1'b1, 1'b1, 1'b1, -1);
        idle(4);
        n_cmp++; if (last_b !== 8'h15 || bus.o_Parity_Err !== 1'b1) begin
            n_bad++; $display("FAIL 5o1_bad: got byte %h perr %b want 15 1", last_b, bus.o_Parity_Err); end
    endtask

    initial begin
        bus.i_Enable = 1'b1;
        bus.i_Clks_Per_Bit = 16'(D);
        bus.i_Data_Bits = 2'd3;
        bus.i_Parity_Mode = 2'd0;
        bus.i_RX_Serial = 1'b1;
        test_reset;
        test_8n1;
        test_parity;
        test_framing;
        test_break;
        test_glitch;
        test_back_to_back;
        test_enable;
        test_rst_abort;
        test_5o1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
